// File: rtl/conv2_accumulate_stage_if.sv
// Handshake/data bundle between the conv2 multiplier stage and the accumulate stage.
// master drives products and control; slave (the accumulate stage) returns the activation.
interface conv2_accumulate_stage_if;
  logic               in_valid;
  logic signed [15:0] prod1;
  logic signed [15:0] prod2;
  logic signed [15:0] prod3;
  logic signed [15:0] prod4;
  logic signed [15:0] prod5;
  logic signed [15:0] prod6;
  logic signed [15:0] bias;
  logic               clear;
  logic [7:0]         out_data;
  logic               out_valid;
  logic [4:0]         beat_count;

  modport master (
    output in_valid, prod1, prod2, prod3, prod4, prod5, prod6, bias, clear,
    input  out_data, out_valid, beat_count
  );

  modport slave (
    input  in_valid, prod1, prod2, prod3, prod4, prod5, prod6, bias, clear,
    output out_data, out_valid, beat_count
  );
endinterface

// File: rtl/conv2_accumulate_stage.sv
// Conv2 accumulate stage: 3-stage adder tree over six products, BEATS-beat accumulation,
// then bias, rounding shift, ReLU and saturation to a 0..127 activation.
module conv2_accumulate_stage #(
  parameter int unsigned BEATS = 3,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned ACC_W = 24
) (
  input logic                      clk,
  input logic                      rst_n,
  conv2_accumulate_stage_if.slave  bus
);

  localparam logic [4:0]  LastBeat = 5'(BEATS - 1);
  localparam int unsigned RoundInt = (SHIFT > 0) ? (32'd1 << (SHIFT - 1)) : 32'd0;
  localparam logic signed [ACC_W-1:0] RoundK = ACC_W'(RoundInt);

  logic signed [16:0]      p12_q, p34_q, p56_q;
  logic signed [16:0]      p12_d, p34_d, p56_d;
  logic                    v1_q, v2_q;
  logic signed [18:0]      tot_q, tot_d;
  logic signed [ACC_W-1:0] acc_q;
  logic [4:0]              beat_count_q;
  logic [7:0]              out_data_q;
  logic                    out_valid_q;

  logic signed [ACC_W-1:0] tot_ext, bias_ext, acc_sum, last_sum, shifted;
  logic [7:0]              act;

  // An all-zero pair loads 0 directly so the adder sees no activity.
  function automatic logic signed [16:0] pair_sum(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
    if (a == 16'sd0 && b == 16'sd0) return 17'sd0;
    return {a[15], a} + {b[15], b};
  endfunction

  always_comb begin
    p12_d = pair_sum(bus.prod1, bus.prod2);
    p34_d = pair_sum(bus.prod3, bus.prod4);
    p56_d = pair_sum(bus.prod5, bus.prod6);
    tot_d = {{2{p12_q[16]}}, p12_q} + {{2{p34_q[16]}}, p34_q} + {{2{p56_q[16]}}, p56_q};
  end

  always_comb begin
    tot_ext  = {{(ACC_W - 19){tot_q[18]}}, tot_q};
    bias_ext = {{(ACC_W - 16){bus.bias[15]}}, bus.bias};
    acc_sum  = acc_q + tot_ext;
    last_sum = acc_sum + bias_ext + RoundK;
    shifted  = last_sum >>> SHIFT;
    if (shifted[ACC_W-1]) begin
      act = 8'd0;
    end else if (|shifted[ACC_W-2:7]) begin
      act = 8'd127;
    end else begin
      act = {1'b0, shifted[6:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p12_q        <= '0;
      p34_q        <= '0;
      p56_q        <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      tot_q        <= '0;
      acc_q        <= '0;
      beat_count_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else if (bus.clear) begin
      // Flush in-flight beats and the partial pixel; out_data keeps its last value.
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      acc_q        <= '0;
      beat_count_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        p12_q <= p12_d;
        p34_q <= p34_d;
        p56_q <= p56_d;
      end
      v2_q <= v1_q;
      if (v1_q) tot_q <= tot_d;
      out_valid_q <= 1'b0;
      if (v2_q) begin
        if (beat_count_q == LastBeat) begin
          out_data_q   <= act;
          out_valid_q  <= 1'b1;
          acc_q        <= '0;
          beat_count_q <= '0;
        end else begin
          acc_q        <= acc_sum;
          beat_count_q <= beat_count_q + 5'd1;
        end
      end
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.beat_count = beat_count_q;

endmodule
